// File: rtl/nqueens_pkg.sv
// Shared constants, scheduler state encoding and the mirror-symmetry helper
// for the N-Queens job scheduler.
package nqueens_pkg;

  localparam int N_WIDTH   = 5;
  localparam int SUM_WIDTH = 24;
  localparam int N_MAX     = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } sched_state_e;

  // For odd n the middle column is its own mirror image, so it counts once.
  function automatic logic is_mid_col(input logic [N_WIDTH-1:0] n,
                                      input logic [N_WIDTH-1:0] col);
    return n[0] && (col == ((n - 1'b1) >> 1));
  endfunction

endpackage

// File: rtl/nqueens_lowest_pick.sv
// Lowest-index priority encoder: reports whether any request is set and the
// index of the lowest one.
module nqueens_lowest_pick #(
  parameter int WIDTH = 4,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/nqueens_job_scheduler.sv
// Splits one N-Queens count into first-row-column jobs (left half only, using
// mirror symmetry), dispatches them to a worker pool and accumulates the total.
module nqueens_job_scheduler #(
  parameter int NUM_WORKERS = 4,
  parameter int N_WIDTH     = nqueens_pkg::N_WIDTH,
  parameter int SUM_WIDTH   = nqueens_pkg::SUM_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [N_WIDTH-1:0]               n_in,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [SUM_WIDTH-1:0]             total,
  output logic [NUM_WORKERS-1:0]           wk_start,
  output logic [N_WIDTH-1:0]               wk_n,
  output logic [NUM_WORKERS*N_WIDTH-1:0]   wk_col,
  input  logic [NUM_WORKERS-1:0]           wk_done,
  input  logic [NUM_WORKERS*SUM_WIDTH-1:0] wk_sum
);
  import nqueens_pkg::*;

  localparam int IDX_W = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
  localparam int ACC_W = SUM_WIDTH + 1;

  sched_state_e           state_q, state_d;
  logic [N_WIDTH-1:0]     n_q, n_d;
  logic [N_WIDTH-1:0]     next_col_q, next_col_d;
  logic [N_WIDTH-1:0]     last_col_q, last_col_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic                   error_q, error_d;
  logic [NUM_WORKERS-1:0] wbusy_q, wbusy_d;
  logic [N_WIDTH-1:0]     col_q [NUM_WORKERS];
  logic [N_WIDTH-1:0]     col_d [NUM_WORKERS];
  logic [SUM_WIDTH-1:0]   sum_arr [NUM_WORKERS];

  logic                   n_legal, start_ok, cols_left;
  logic                   disp_valid, coll_valid;
  logic [IDX_W-1:0]       disp_idx, coll_idx;
  logic [NUM_WORKERS-1:0] disp_onehot;

  for (genvar i = 0; i < NUM_WORKERS; i++) begin : g_sum
    assign sum_arr[i] = wk_sum[i*SUM_WIDTH +: SUM_WIDTH];
  end

  assign n_legal   = (n_in != '0) && (n_in <= N_WIDTH'(N_MAX));
  assign start_ok  = start && (state_q != ST_RUN);
  assign cols_left = (state_q == ST_RUN) && (next_col_q <= last_col_q);

  nqueens_lowest_pick #(.WIDTH(NUM_WORKERS), .IDX_W(IDX_W)) u_disp_pick (
    .req   (~wbusy_q & {NUM_WORKERS{cols_left}}),
    .valid (disp_valid),
    .idx   (disp_idx)
  );

  assign disp_onehot = disp_valid ? (NUM_WORKERS'(1) << disp_idx) : '0;

  nqueens_lowest_pick #(.WIDTH(NUM_WORKERS), .IDX_W(IDX_W)) u_coll_pick (
    .req   (wbusy_q & wk_done & ~disp_onehot),
    .valid (coll_valid),
    .idx   (coll_idx)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    n_d        = n_q;
    next_col_d = next_col_q;
    last_col_d = last_col_q;
    acc_d      = acc_q;
    error_d    = error_q;
    wbusy_d    = wbusy_q;
    col_d      = col_q;
    if (start_ok) begin
      n_d        = n_in;
      acc_d      = '0;
      next_col_d = '0;
      last_col_d = (n_in - 1'b1) >> 1;
      error_d    = !n_legal;
      wbusy_d    = '0;
    end else if (state_q == ST_RUN) begin
      if (disp_valid) begin
        wbusy_d[disp_idx] = 1'b1;
        col_d[disp_idx]   = next_col_q;
        next_col_d        = next_col_q + 1'b1;
      end
      if (coll_valid) begin
        wbusy_d[coll_idx] = 1'b0;
        acc_d = acc_q + (is_mid_col(n_q, col_q[coll_idx]) ? {1'b0, sum_arr[coll_idx]}
                                                          : {sum_arr[coll_idx], 1'b0});
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = n_legal ? ST_RUN : ST_DONE;
      ST_RUN:  if ((next_col_d > last_col_q) && (wbusy_d == '0)) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      next_col_q <= '0;
      last_col_q <= '0;
      acc_q      <= '0;
      error_q    <= 1'b0;
      wbusy_q    <= '0;
      // NOTE: the column registers feed wk_col directly, so they are reset too.
      for (int i = 0; i < NUM_WORKERS; i++) col_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      next_col_q <= next_col_d;
      last_col_q <= last_col_d;
      acc_q      <= acc_d;
      error_q    <= error_d;
      wbusy_q    <= wbusy_d;
      col_q      <= col_d;
    end
  end

  // A dispatched worker sees its new column in the same cycle as its wk_start.
  always_comb begin
    busy     = (state_q == ST_RUN);
    done     = (state_q == ST_DONE);
    error    = error_q;
    total    = acc_q[SUM_WIDTH-1:0];
    wk_start = disp_onehot;
    wk_n     = n_q;
    wk_col   = '0;
    for (int i = 0; i < NUM_WORKERS; i++) begin
      wk_col[i*N_WIDTH +: N_WIDTH] = disp_onehot[i] ? next_col_q : col_q[i];
    end
  end

endmodule

// File: tb/tb_nqueens_job_scheduler.sv
// Scoreboard bench: a 4-worker and a 2-worker scheduler share start/n_in and
// each drives its own pool of stub workers with table-driven partial counts.
module tb_nqueens_job_scheduler;

  localparam int NW_A = 4;
  localparam int NW_B = 2;
  localparam int NW   = 5;
  localparam int SW   = 24;

  logic clk = 1'b0;
  logic reset, start;
  logic [NW-1:0] n_in;

  logic busy_a, done_a, error_a, busy_b, done_b, error_b;
  logic [SW-1:0] total_a, total_b;
  logic [NW_A-1:0] wk_start_a, wk_done_a;
  logic [NW_B-1:0] wk_start_b, wk_done_b;
  logic [NW-1:0] wk_n_a, wk_n_b;
  logic [NW_A*NW-1:0] wk_col_a;
  logic [NW_B*NW-1:0] wk_col_b;
  logic [NW_A*SW-1:0] wk_sum_a;
  logic [NW_B*SW-1:0] wk_sum_b;

  always #5 clk = ~clk;

  nqueens_job_scheduler #(.NUM_WORKERS(NW_A), .N_WIDTH(NW), .SUM_WIDTH(SW)) dut_a (
    .clk(clk), .reset(reset), .start(start), .n_in(n_in),
    .busy(busy_a), .done(done_a), .error(error_a), .total(total_a),
    .wk_start(wk_start_a), .wk_n(wk_n_a), .wk_col(wk_col_a),
    .wk_done(wk_done_a), .wk_sum(wk_sum_a)
  );

  nqueens_job_scheduler #(.NUM_WORKERS(NW_B), .N_WIDTH(NW), .SUM_WIDTH(SW)) dut_b (
    .clk(clk), .reset(reset), .start(start), .n_in(n_in),
    .busy(busy_b), .done(done_b), .error(error_b), .total(total_b),
    .wk_start(wk_start_b), .wk_n(wk_n_b), .wk_col(wk_col_b),
    .wk_done(wk_done_b), .wk_sum(wk_sum_b)
  );

  // Stub workers: per-column count from tab[], latency lat, optional hold.
  int   tab [16];
  int   lat;
  logic hold;
  int   cnt_a [NW_A];
  logic pend_a [NW_A];
  int   scol_a [NW_A];
  int   cnt_b [NW_B];
  logic pend_b [NW_B];
  int   scol_b [NW_B];

  always @(posedge clk) begin
    for (int i = 0; i < NW_A; i++) begin
      if (reset) begin
        pend_a[i] <= 1'b0; cnt_a[i] <= 0; scol_a[i] <= 0;
        wk_done_a[i] <= 1'b0; wk_sum_a[i*SW +: SW] <= '0;
      end else if (wk_start_a[i]) begin
        pend_a[i] <= 1'b1; cnt_a[i] <= lat; wk_done_a[i] <= 1'b0;
        scol_a[i] <= int'(wk_col_a[i*NW +: NW]);
      end else if (pend_a[i]) begin
        if (cnt_a[i] > 1) cnt_a[i] <= cnt_a[i] - 1;
        else if (!hold) begin
          wk_done_a[i] <= 1'b1; pend_a[i] <= 1'b0;
          wk_sum_a[i*SW +: SW] <= SW'(tab[scol_a[i] % 16]);
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NW_B; i++) begin
      if (reset) begin
        pend_b[i] <= 1'b0; cnt_b[i] <= 0; scol_b[i] <= 0;
        wk_done_b[i] <= 1'b0; wk_sum_b[i*SW +: SW] <= '0;
      end else if (wk_start_b[i]) begin
        pend_b[i] <= 1'b1; cnt_b[i] <= lat; wk_done_b[i] <= 1'b0;
        scol_b[i] <= int'(wk_col_b[i*NW +: NW]);
      end else if (pend_b[i]) begin
        if (cnt_b[i] > 1) cnt_b[i] <= cnt_b[i] - 1;
        else if (!hold) begin
          wk_done_b[i] <= 1'b1; pend_b[i] <= 1'b0;
          wk_sum_b[i*SW +: SW] <= SW'(tab[scol_b[i] % 16]);
        end
      end
    end
  end

  // Dispatch log, sampled on the falling edge.
  typedef struct { int cyc; int wk; int col; } disp_t;
  disp_t log_a[$];
  disp_t log_b[$];
  int cyc = 0;
  int pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < NW_A; i++)
      if (wk_start_a[i]) begin
        log_a.push_back('{cyc, i, int'(wk_col_a[i*NW +: NW])});
        pulses <= pulses + 1;
      end
    for (int i = 0; i < NW_B; i++)
      if (wk_start_b[i]) begin
        log_b.push_back('{cyc, i, int'(wk_col_b[i*NW +: NW])});
        pulses <= pulses + 1;
      end
  end

  typedef struct { int total; logic err; } exp_t;
  exp_t sb_a[$];
  exp_t sb_b[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pushes the expected result, issues start, then pops/compares on each done.
  task automatic run_job(input int n, input int exp_total, input logic exp_err,
                         input int release_at, output int acc_cyc);
    exp_t e;
    logic got_a, got_b;
    int   rel;
    sb_a.push_back('{exp_total, exp_err});
    sb_b.push_back('{exp_total, exp_err});
    hold = (release_at > 0);
    @(negedge clk);
    n_in = NW'(n); start = 1'b1; acc_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    if (exp_err) begin
      check("err_done_t1", done_a, 1);
      check("err_flag_t1", error_a, 1);
    end else begin
      check("busy_t1", busy_a, 1);
    end
    got_a = 1'b0; got_b = 1'b0; rel = 0;
    for (int k = 0; k < 400 && !(got_a && got_b); k++) begin
      if (k > 0) @(negedge clk);
      if (release_at > 0 && k == release_at) begin hold = 1'b0; rel = k; end
      if (!got_a && done_a) begin
        got_a = 1'b1; e = sb_a.pop_front();
        check("total_a", total_a, e.total);
        check("error_a", error_a, e.err);
        check("busy_at_done_a", busy_a, 0);
        if (release_at > 0) check("drain_cycles_a", k - rel, 5);
      end
      if (!got_b && done_b) begin
        got_b = 1'b1; e = sb_b.pop_front();
        check("total_b", total_b, e.total);
        check("error_b", error_b, e.err);
      end
    end
    if (!got_a) check("timeout_a", 0, 1);
    if (!got_b) check("timeout_b", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_done"}, done_a, 0);
    check({tag, "_error"}, error_a, 0);
    check({tag, "_total"}, total_a, 0);
    check({tag, "_wk_start"}, wk_start_a, 0);
    check({tag, "_wk_n"}, wk_n_a, 0);
    check({tag, "_wk_col"}, wk_col_a, 0);
    check({tag, "_busy_b"}, busy_b, 0);
  endtask

  initial begin
    int acc, base, base_b, p;
    reset = 1'b1; start = 1'b0; n_in = '0; hold = 1'b0; lat = 5;
    for (int i = 0; i < 16; i++) tab[i] = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // n=8: four consecutive dispatches, total 92
    tab[0] = 4; tab[1] = 8; tab[2] = 16; tab[3] = 18; lat = 5;
    base = log_a.size();
    run_job(8, 92, 1'b0, 0, acc);
    check("n8_disp_count", log_a.size() - base, 4);
    for (int j = 0; j < 4; j++) begin
      check("n8_disp_cyc", log_a[base+j].cyc, acc + 1 + j);
      check("n8_disp_wk", log_a[base+j].wk, j);
      check("n8_disp_col", log_a[base+j].col, j);
    end

    // n=5 with counts of 2: middle column added once; 2-worker pool stalls col 2
    for (int i = 0; i < 16; i++) tab[i] = 2;
    lat = 3;
    base_b = log_b.size();
    run_job(5, 10, 1'b0, 0, acc);
    check("n5_b_disp_count", log_b.size() - base_b, 3);
    check("n5_b_disp1_cyc", log_b[base_b+1].cyc, log_b[base_b].cyc + 1);
    check("n5_b_disp2_cyc", log_b[base_b+2].cyc, log_b[base_b].cyc + 5);
    check("n5_b_disp2_wk", log_b[base_b+2].wk, 0);
    check("n5_b_disp2_col", log_b[base_b+2].col, 2);

    // n=1 and n=2 corner boards
    tab[0] = 1;
    run_job(1, 1, 1'b0, 0, acc);
    tab[0] = 0;
    run_job(2, 0, 1'b0, 0, acc);

    // illegal sizes: immediate done/error, no dispatch
    p = pulses;
    run_job(0, 0, 1'b1, 0, acc);
    run_job(17, 0, 1'b1, 0, acc);
    check("illegal_no_wk_start", pulses - p, 0);

    // simultaneous wk_done on all four workers drains in four cycles
    tab[0] = 4; tab[1] = 8; tab[2] = 16; tab[3] = 18; lat = 5;
    run_job(8, 92, 1'b0, 15, acc);

    // reset mid-run, with an ignored start while busy
    tab[0] = 0; tab[1] = 1; lat = 20;
    @(negedge clk); n_in = 5'd8; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    n_in = 5'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_start_ignored_wk_n", wk_n_a, 8);
    check("busy_start_ignored_busy", busy_a, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    run_job(4, 2, 1'b0, 0, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
